// File: rtl/mem_cache.sv
// mem_cache
//   Direct-mapped, write-through, read-allocate cache sitting between the CPU
//   core and memory_controller. The CPU port uses the same request/complete
//   handshake as the controller, so the core plugs in unchanged.
//   Read misses refill a whole line as WORDS sequential single-word reads.
//   Stores always go downstream (one transaction) and update the line only on hit.
//
// Ports
//   clk, rst_n (sync, active-low), ena (clock enable: low freezes everything)
//   cpu_address / cpu_write_value / cpu_write_enable / cpu_request   CPU request
//   cpu_read_value / cpu_request_complete                            CPU response
//   mem_address / mem_write_value / mem_write_enable / mem_request   to controller
//   mem_read_value / mem_request_complete                            from controller
module mem_cache #(
    parameter int WORD_SIZE            = 16,
    parameter int ADDRESS_LEN          = 17,
    parameter int CACHE_SIZE           = 8,
    parameter int CACHE_LINE_SIZE_BITS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [ADDRESS_LEN-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0]   cpu_write_value,
    input  logic                   cpu_write_enable,
    input  logic                   cpu_request,
    output logic [WORD_SIZE-1:0]   cpu_read_value,
    output logic                   cpu_request_complete,
    output logic [ADDRESS_LEN-1:0] mem_address,
    output logic [WORD_SIZE-1:0]   mem_write_value,
    output logic                   mem_write_enable,
    output logic                   mem_request,
    input  logic [WORD_SIZE-1:0]   mem_read_value,
    input  logic                   mem_request_complete
);

    localparam int WORDS = CACHE_LINE_SIZE_BITS / WORD_SIZE;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(CACHE_SIZE);
    // Bit 0 is the byte-within-word offset and is never used.
    localparam int TAG_W = ADDRESS_LEN - IDX_W - OFF_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FILL_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                             r_state;
    logic [WORDS-1:0][WORD_SIZE-1:0]    r_lines [CACHE_SIZE];
    logic [TAG_W-1:0]                   r_tags  [CACHE_SIZE];
    logic [CACHE_SIZE-1:0]              r_valid;
    logic [ADDRESS_LEN-1:1]             r_addr;
    logic [OFF_W-1:0]                   r_cnt;

    logic [OFF_W-1:0] w_cpu_off;
    logic [IDX_W-1:0] w_cpu_idx;
    logic [TAG_W-1:0] w_cpu_tag;
    logic [OFF_W-1:0] w_r_off;
    logic [IDX_W-1:0] w_r_idx;
    logic [TAG_W-1:0] w_r_tag;
    logic             w_cpu_hit;
    logic             w_r_hit;
    logic [OFF_W-1:0] w_cnt_nxt;
    logic             w_unused;

    assign w_cpu_off = cpu_address[OFF_W:1];
    assign w_cpu_idx = cpu_address[OFF_W+IDX_W:OFF_W+1];
    assign w_cpu_tag = cpu_address[ADDRESS_LEN-1:OFF_W+IDX_W+1];
    assign w_r_off   = r_addr[OFF_W:1];
    assign w_r_idx   = r_addr[OFF_W+IDX_W:OFF_W+1];
    assign w_r_tag   = r_addr[ADDRESS_LEN-1:OFF_W+IDX_W+1];

    // Hit against the live CPU address (IDLE decision) and against the latched
    // address (write-through update once the store has been acknowledged).
    assign w_cpu_hit = r_valid[w_cpu_idx] && (r_tags[w_cpu_idx] == w_cpu_tag);
    assign w_r_hit   = r_valid[w_r_idx]   && (r_tags[w_r_idx]   == w_r_tag);

    assign w_cnt_nxt = r_cnt + OFF_W'(1);

    // Byte-select bit has no function in a word-aligned cache.
    assign w_unused = cpu_address[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_valid              <= '0;
            r_addr               <= '0;
            r_cnt                <= '0;
            cpu_read_value       <= '0;
            cpu_request_complete <= 1'b0;
            mem_address          <= '0;
            mem_write_value      <= '0;
            mem_write_enable     <= 1'b0;
            mem_request          <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    // A controller still showing complete from the previous
                    // transaction must drop it before anything new is issued.
                    if (cpu_request && !mem_request_complete) begin
                        r_addr <= cpu_address[ADDRESS_LEN-1:1];
                        if (cpu_write_enable) begin
                            mem_address      <= {cpu_address[ADDRESS_LEN-1:1], 1'b0};
                            mem_write_value  <= cpu_write_value;
                            mem_write_enable <= 1'b1;
                            mem_request      <= 1'b1;
                            r_state          <= S_WRITE;
                        end else if (w_cpu_hit) begin
                            cpu_read_value       <= r_lines[w_cpu_idx][w_cpu_off];
                            cpu_request_complete <= 1'b1;
                            r_state              <= S_DONE;
                        end else begin
                            r_cnt            <= '0;
                            mem_address      <= {w_cpu_tag, w_cpu_idx, {OFF_W{1'b0}}, 1'b0};
                            mem_write_enable <= 1'b0;
                            mem_request      <= 1'b1;
                            r_state          <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (mem_request_complete) begin
                        r_lines[w_r_idx][r_cnt] <= mem_read_value;
                        mem_request             <= 1'b0;
                        r_state                 <= S_FILL_GAP;
                    end
                end

                S_FILL_GAP: begin
                    // Next word only once the controller has lowered complete,
                    // so a stale complete is never taken for the next word.
                    if (!mem_request_complete) begin
                        if (r_cnt == OFF_W'(WORDS - 1)) begin
                            r_valid[w_r_idx]     <= 1'b1;
                            r_tags[w_r_idx]      <= w_r_tag;
                            cpu_read_value       <= r_lines[w_r_idx][w_r_off];
                            cpu_request_complete <= 1'b1;
                            r_state              <= S_DONE;
                        end else begin
                            r_cnt       <= w_cnt_nxt;
                            mem_address <= {w_r_tag, w_r_idx, w_cnt_nxt, 1'b0};
                            mem_request <= 1'b1;
                            r_state     <= S_FILL;
                        end
                    end
                end

                S_WRITE: begin
                    // No write-allocate: a miss leaves cache contents alone.
                    if (mem_request_complete) begin
                        mem_request <= 1'b0;
                        if (w_r_hit) begin
                            r_lines[w_r_idx][w_r_off] <= mem_write_value;
                        end
                        cpu_request_complete <= 1'b1;
                        r_state              <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!cpu_request) begin
                        cpu_request_complete <= 1'b0;
                        r_state              <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cache.sv
// tb_mem_cache
//   Drives mem_cache with directed and random loads/stores. A behavioural
//   memory controller with random latency and random complete-hold serves the
//   downstream port and logs every transaction. A reference model (flat word
//   memory plus per-index valid/tag) predicts hit/miss, expected traffic and
//   load data.
module tb_mem_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [16:0] cpu_address;
    logic [15:0] cpu_write_value;
    logic        cpu_write_enable;
    logic        cpu_request;
    logic [15:0] cpu_read_value;
    logic        cpu_request_complete;
    logic [16:0] mem_address;
    logic [15:0] mem_write_value;
    logic        mem_write_enable;
    logic        mem_request;
    logic [15:0] mem_read_value;
    logic        mem_request_complete;

    mem_cache dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ena                  (ena),
        .cpu_address          (cpu_address),
        .cpu_write_value      (cpu_write_value),
        .cpu_write_enable     (cpu_write_enable),
        .cpu_request          (cpu_request),
        .cpu_read_value       (cpu_read_value),
        .cpu_request_complete (cpu_request_complete),
        .mem_address          (mem_address),
        .mem_write_value      (mem_write_value),
        .mem_write_enable     (mem_write_enable),
        .mem_request          (mem_request),
        .mem_read_value       (mem_read_value),
        .mem_request_complete (mem_request_complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [16:0] a;
        logic [15:0] d;
    } tx_t;

    int errors = 0;
    int checks = 0;

    logic [15:0] sram    [65536];
    logic [15:0] ref_mem [65536];
    bit          rv [8];
    logic [9:0]  rt [8];
    tx_t         txlog [$];
    int          viol = 0;

    // ---------------- behavioural memory controller ----------------
    bit          m_busy = 0;
    int          m_wait = 0;
    int          m_hold = 0;
    bit          m_prev_req = 0;
    logic [16:0] m_addr;
    logic        m_we;
    logic [15:0] m_wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_request_complete = 1'b0;
            m_busy = 0;
            m_hold = 0;
        end else begin
            if (mem_request && !m_prev_req && mem_request_complete) viol++;
            if (mem_request_complete) begin
                if (!mem_request) begin
                    if (m_hold == 0) mem_request_complete = 1'b0;
                    else m_hold--;
                end
            end else if (mem_request) begin
                if (!m_busy) begin
                    m_busy = 1;
                    m_wait = $urandom_range(0, 3);
                    m_addr = mem_address;
                    m_we   = mem_write_enable;
                    m_wd   = mem_write_value;
                    txlog.push_back('{we: mem_write_enable, a: mem_address, d: mem_write_value});
                end
                if (m_wait == 0) begin
                    if (m_we) sram[m_addr[16:1]] = m_wd;
                    else      mem_read_value = sram[m_addr[16:1]];
                    mem_request_complete = 1'b1;
                    m_busy = 0;
                    m_hold = $urandom_range(0, 2);
                end else begin
                    m_wait--;
                end
            end
        end
        m_prev_req = mem_request;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete CPU transaction, called and returning on a negedge.
    task automatic access(input logic [16:0] a, input logic we, input logic [15:0] d, input string tag);
        int          start;
        int          cyc;
        int          n_exp;
        int          idx;
        logic [9:0]  tg;
        bit          hit;
        logic [16:0] base;
        idx  = int'(a[6:4]);
        tg   = a[16:7];
        hit  = rv[idx] && (rt[idx] == tg);
        base = {a[16:4], 4'h0};
        // For hits, let any stale controller complete drain first so the
        // one-edge latency can be measured; misses/writes exercise the guard.
        if (!we && hit) begin
            cyc = 0;
            while (mem_request_complete && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = txlog.size();
        cpu_address      = a;
        cpu_write_enable = we;
        cpu_write_value  = d;
        cpu_request      = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cpu_request_complete) break;
        end
        chk({tag, ".complete"}, 32'(cpu_request_complete), 32'd1);
        chk({tag, ".mem_req_low"}, 32'(mem_request), 32'd0);
        if (!we) chk({tag, ".rdata"}, 32'(cpu_read_value), 32'(ref_mem[a[16:1]]));
        if (!we && hit) chk({tag, ".hit_latency"}, cyc, 1);
        n_exp = we ? 1 : (hit ? 0 : 8);
        chk({tag, ".ntx"}, txlog.size() - start, n_exp);
        if (txlog.size() - start == n_exp) begin
            for (int k = 0; k < n_exp; k++) begin
                if (we) begin
                    chk({tag, ".wr_we"}, 32'(txlog[start+k].we), 32'd1);
                    chk({tag, ".wr_addr"}, 32'(txlog[start+k].a), 32'({a[16:1], 1'b0}));
                    chk({tag, ".wr_data"}, 32'(txlog[start+k].d), 32'(d));
                end else begin
                    chk({tag, ".fill_we"}, 32'(txlog[start+k].we), 32'd0);
                    chk({tag, ".fill_addr"}, 32'(txlog[start+k].a), 32'(base + 17'(2*k)));
                end
            end
        end
        cpu_request = 1'b0;
        @(negedge clk);
        chk({tag, ".complete_drop"}, 32'(cpu_request_complete), 32'd0);
        chk({tag, ".reissue"}, viol, 0);
        if (we) ref_mem[a[16:1]] = d;
        else if (!hit) begin
            rv[idx] = 1;
            rt[idx] = tg;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        int cyc;
        rst_n            = 1'b0;
        ena              = 1'b1;
        cpu_address      = '0;
        cpu_write_value  = '0;
        cpu_write_enable = 1'b0;
        cpu_request      = 1'b0;
        mem_read_value   = '0;
        mem_request_complete = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 16'($urandom);
            ref_mem[i] = sram[i];
        end
        for (int k = 0; k < 8; k++) begin
            sram[17'h80 + k]    = 16'h1230 + 16'(k);
            ref_mem[17'h80 + k] = 16'h1230 + 16'(k);
        end
        for (int i = 0; i < 8; i++) begin
            rv[i] = 0;
            rt[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.complete", 32'(cpu_request_complete), 32'd0);
        chk("rst.rdata", 32'(cpu_read_value), 32'd0);
        chk("rst.mem_req", 32'(mem_request), 32'd0);
        chk("rst.mem_addr", 32'(mem_address), 32'd0);
        chk("rst.mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst.mem_wd", 32'(mem_write_value), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, hit, write hit then read hit
        access(17'h0106, 1'b0, 16'h0, "cold_miss");
        chk("cold_miss.value", 32'(cpu_read_value), 32'h1233);
        access(17'h010C, 1'b0, 16'h0, "read_hit");
        chk("read_hit.value", 32'(cpu_read_value), 32'h1236);
        access(17'h0104, 1'b1, 16'hBEEF, "write_hit");
        access(17'h0104, 1'b0, 16'h0, "write_hit_rd");
        chk("write_hit_rd.value", 32'(cpu_read_value), 32'hBEEF);

        // Clock enable: a hit must not progress while ena is low
        cyc = 0;
        while (mem_request_complete && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        ena = 1'b0;
        cpu_address = 17'h010A;
        cpu_write_enable = 1'b0;
        cpu_request = 1'b1;
        repeat (3) @(negedge clk);
        chk("ena.frozen", 32'(cpu_request_complete), 32'd0);
        ena = 1'b1;
        @(negedge clk);
        chk("ena.resume", 32'(cpu_request_complete), 32'd1);
        chk("ena.value", 32'(cpu_read_value), 32'h1235);
        ena = 1'b0;
        cpu_request = 1'b0;
        repeat (2) @(negedge clk);
        chk("ena.hold_done", 32'(cpu_request_complete), 32'd1);
        ena = 1'b1;
        @(negedge clk);
        chk("ena.done_exit", 32'(cpu_request_complete), 32'd0);

        // Conflict eviction on index 0
        access(17'h0180, 1'b0, 16'h0, "evict");
        access(17'h0100, 1'b0, 16'h0, "refill");
        chk("refill.value", 32'(cpu_read_value), 32'h1230);

        // Write miss: no allocate, later read fills with the new data
        access(17'h0200, 1'b1, 16'h5555, "write_miss");
        access(17'h0200, 1'b0, 16'h0, "write_miss_rd");
        chk("write_miss_rd.value", 32'(cpu_read_value), 32'h5555);

        // Reset during the 4th fill word
        start = txlog.size();
        cpu_address = 17'h0346;
        cpu_write_enable = 1'b0;
        cpu_request = 1'b1;
        cyc = 0;
        while (txlog.size() - start < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst.reached_word4", txlog.size() - start, 4);
        rst_n = 1'b0;
        cpu_request = 1'b0;
        @(negedge clk);
        chk("midrst.mem_req", 32'(mem_request), 32'd0);
        chk("midrst.complete", 32'(cpu_request_complete), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rv[i] = 0;
        @(negedge clk);
        access(17'h0346, 1'b0, 16'h0, "midrst_reread");
        access(17'h0106, 1'b0, 16'h0, "midrst_cold");

        // Random mix over a small tag set so hits, conflicts and write hits occur
        for (int n = 0; n < 60; n++) begin
            logic [16:0] a;
            logic        we;
            a  = {10'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 1'b0};
            we = ($urandom_range(0, 3) == 0);
            access(a, we, 16'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_cache.md
# mem_cache

Direct-mapped, write-through, read-allocate cache between the CPU core and `memory_controller`. The CPU-side port mirrors the controller's request/complete handshake, so the core connects to it unchanged. Misses go downstream as eight sequential 16-bit word requests that fill one 128-bit line. Read hits complete without any SPI SRAM traffic.

## Interface
- `WORD_SIZE`, 16, data word width in bits
- `ADDRESS_LEN`, 17, byte address width
- `CACHE_SIZE`, 8, number of lines
- `CACHE_LINE_SIZE_BITS`, 128, line width (8 words)
- `clk`  in  1  single clock
- `rst_n`  in  1  reset; synchronous, active-low
- `ena`  in  1  clock enable; when low all state, including outputs, holds
- `cpu_address`  in  17  byte address; bit 0 is ignored (word-aligned)
- `cpu_write_value`  in  16  store data
- `cpu_write_enable`  in  1  1 = store, 0 = load
- `cpu_request`  in  1  request; held high until `cpu_request_complete` is seen
- `cpu_read_value`  out  16  load data, valid while `cpu_request_complete`=1
- `cpu_request_complete`  out  1  registered completion
- `mem_address`  out  17  to controller
- `mem_write_value`  out  16  to controller
- `mem_write_enable`  out  1  to controller
- `mem_request`  out  1  to controller
- `mem_read_value`  in  16  from controller
- `mem_request_complete`  in  1  from controller

## Operation
- **Address split**
  - word offset = addr[3:1]
  - index = addr[6:4]
  - tag = addr[16:7] (10 bits)
- **Storage:** 8 data lines of 128 bits, 8 tags of 10 bits, 8 valid bits. Word w occupies line bits [16w+15:16w].
- **Hit:** valid[index] && tag[index] == tag.
- **States:** IDLE, FILL, FILL_GAP, WRITE, DONE.
- **IDLE**
  - Acts on an edge where `cpu_request`=1 and `mem_request_complete`=0.
  - Latches address, data and write enable.
  - Read hit: `cpu_read_value` <= cached word, `cpu_request_complete` <= 1, go to DONE.
  - Read miss: word counter <= 0, `mem_address` <= {tag, index, 3'd0, 1'b0}, `mem_write_enable` <= 0, `mem_request` <= 1, go to FILL.
  - Write: `mem_address` <= latched address with bit 0 = 0, `mem_write_value` <= data, `mem_write_enable` <= 1, `mem_request` <= 1, go to WRITE.
- **FILL**
  - On `mem_request_complete`=1: write `mem_read_value` into word[counter] of line[index], `mem_request` <= 0, go to FILL_GAP.
- **FILL_GAP**
  - Waits until `mem_request_complete` is sampled 0.
  - If counter == 7: set valid[index] and tag[index], `cpu_read_value` <= requested word (as filled), `cpu_request_complete` <= 1, go to DONE.
  - Otherwise: counter += 1, `mem_address` <= line base + 2·(counter+1), `mem_request` <= 1, go to FILL.
- **WRITE** (write-through, no write-allocate)
  - On `mem_request_complete`=1: `mem_request` <= 0; if hit, update the cached word; `cpu_request_complete` <= 1; go to DONE.
  - A write miss does not change cache state.
  - `cpu_read_value` is unchanged by writes.
- **DONE**
  - Holds `cpu_request_complete`=1 while `cpu_request`=1.
  - On `cpu_request` sampled 0: `cpu_request_complete` <= 0, go to IDLE.
- **Outstanding requests:** only one at a time. CPU inputs are ignored outside IDLE.

## Timing
- **Reset values:** all valid bits 0, state IDLE, every output 0. Tags and data are don't-care.
- **Reset mid-operation:** forces IDLE. `mem_request` = 0 and `cpu_request_complete` = 0 after that edge. A partially filled line stays invalid.
- **Read hit:** request sampled at edge N; `cpu_request_complete` is high after edge N, with zero downstream traffic.
- **Read miss:** 8 downstream transactions. Between words, `mem_request` is low for at least one cycle, and until the controller's complete is observed low.
- **Write:** exactly 1 downstream transaction. Completion follows the controller's complete by 1 edge.
- **`ena`=0:** nothing advances, including the FILL_GAP wait.
- **Reissue guard:** IDLE never issues a downstream request while `mem_request_complete` is still 1.

## Test plan
- **Cold read miss:** reset, SRAM word at byte address 0x100+2k = 0x1230+k. Read 0x0106 -> downstream reads in order 0x100, 0x102, …, 0x10E; then `cpu_read_value`=0x1233 with `cpu_request_complete`=1.
- **Read hit:** following the cold miss, read 0x010C -> complete one edge after the request, `cpu_read_value`=0x1236, `mem_request` stays 0.
- **Write hit:** write 0xBEEF to 0x0104 -> one downstream write at 0x0104 with `mem_write_enable`=1. Then read 0x0104 -> hit returning 0xBEEF, no downstream traffic.
- **Conflict eviction:** read 0x0180 (same index 0, different tag) -> 8-word refill from 0x180. A following read of 0x0100 misses again with a full refill.
- **Write miss:** write 0x5555 to 0x0200 -> one downstream write and no fill. A following read of 0x0200 misses, fills, and returns 0x5555.
- **Reset mid-fill:** assert `rst_n`=0 during the 4th fill word -> `mem_request`=0 and `cpu_request_complete`=0 after that edge. Re-reading the same address performs a full 8-word refill.
